// File: rtl/i2c_slave_mem.sv
// i2c_slave_mem: I2C target presenting a byte memory like a 24-series EEPROM (16-bit addressing).
// SCL/SDA are oversampled on clk; SDA is driven open-drain through sda_oe.
module i2c_slave_mem #(
  parameter logic [6:0] DEVICE_ADDR = 7'b1010_000,
  parameter int ADDR_BITS = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 scl,
  input  logic                 sda_i,
  output logic                 sda_oe,
  output logic                 busy,
  output logic                 wr_valid,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [7:0]           wr_data
);
  localparam int DEPTH = 2**ADDR_BITS;
  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, ACK_DEV, ADDR_HI, ACK_HI, ADDR_LO, ACK_LO,
    WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;
  state_t r_state;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic r_scl_d, r_sda_d, r_rw;
  logic [7:0] r_shift, r_tx, r_addr_hi;
  logic [3:0] r_cnt;
  logic [ADDR_BITS-1:0] r_ptr;
  logic [7:0] r_mem [DEPTH];
  logic w_scl, w_sda, w_rise, w_fall, w_start, w_stop, w_recv, w_we, w_match;
  logic [7:0] w_byte, w_rd;
  assign w_scl   = r_scl_sync[SYNC_STAGES-1];
  assign w_sda   = r_sda_sync[SYNC_STAGES-1];
  assign w_rise  = w_scl & ~r_scl_d;
  assign w_fall  = ~w_scl & r_scl_d;
  assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_recv  = r_state inside {DEV_ADDR, ADDR_HI, ADDR_LO, WR_DATA};
  assign w_byte  = {r_shift[6:0], w_sda};
  assign w_we    = r_state == WR_DATA && w_rise && r_cnt == 4'd7;
  assign w_match = r_shift[7:1] == DEVICE_ADDR;
  assign w_rd    = r_mem[r_ptr];
  // Memory is deliberately left out of reset so contents survive n_reset.
  always_ff @(posedge clk)
    if (w_we) r_mem[r_ptr] <= w_byte;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_state    <= IDLE;
      r_shift    <= '0;
      r_tx       <= '0;
      r_addr_hi  <= '0;
      r_cnt      <= '0;
      r_rw       <= 1'b0;
      r_ptr      <= '0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      wr_valid   <= w_we;
      if (w_we) begin
        wr_addr <= r_ptr;
        wr_data <= w_byte;
      end
      if (w_start) begin
        r_state <= DEV_ADDR;
        r_cnt   <= '0;
        sda_oe  <= 1'b0;
      end else if (w_stop) begin
        r_state <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (w_rise) begin
        if (w_recv) begin
          r_shift <= w_byte;
          r_cnt   <= r_cnt + 4'd1;
        end
        if (r_state == RD_ACK) begin
          r_ptr <= r_ptr + 1'b1;
          if (w_sda) begin
            busy    <= 1'b0;
            r_state <= WAIT_STOP;
          end
        end
      end else if (w_fall) begin
        // Every state change that touches SDA happens here, while SCL is low.
        case (r_state)
          DEV_ADDR: if (r_cnt == 4'd8) begin
            r_cnt   <= '0;
            r_rw    <= r_shift[0];
            sda_oe  <= w_match;
            busy    <= busy | w_match;
            r_state <= w_match ? ACK_DEV : WAIT_STOP;
          end
          ADDR_HI: if (r_cnt == 4'd8) begin
            r_cnt     <= '0;
            r_addr_hi <= r_shift;
            sda_oe    <= 1'b1;
            r_state   <= ACK_HI;
          end
          ADDR_LO: if (r_cnt == 4'd8) begin
            r_cnt   <= '0;
            r_ptr   <= ADDR_BITS'({r_addr_hi, r_shift});
            sda_oe  <= 1'b1;
            r_state <= ACK_LO;
          end
          WR_DATA: if (r_cnt == 4'd8) begin
            r_cnt   <= '0;
            sda_oe  <= 1'b1;
            r_state <= ACK_WR;
          end
          ACK_DEV: begin
            r_tx    <= w_rd;
            r_cnt   <= {3'b0, r_rw};
            sda_oe  <= r_rw ? ~w_rd[7] : 1'b0;
            r_state <= r_rw ? RD_DATA : ADDR_HI;
          end
          ACK_HI: begin
            sda_oe  <= 1'b0;
            r_state <= ADDR_LO;
          end
          ACK_LO: begin
            sda_oe  <= 1'b0;
            r_state <= WR_DATA;
          end
          ACK_WR: begin
            sda_oe  <= 1'b0;
            r_ptr   <= r_ptr + 1'b1;
            r_state <= WR_DATA;
          end
          RD_DATA: if (r_cnt == 4'd8) begin
            sda_oe  <= 1'b0;
            r_state <= RD_ACK;
          end else begin
            sda_oe <= ~r_tx[6];
            r_tx   <= r_tx << 1;
            r_cnt  <= r_cnt + 4'd1;
          end
          RD_ACK: begin
            r_tx    <= w_rd;
            r_cnt   <= 4'd1;
            sda_oe  <= ~w_rd[7];
            r_state <= RD_DATA;
          end
          WAIT_STOP: sda_oe <= 1'b0;
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_i2c_slave_mem.sv
// tb_i2c_slave_mem: bit-banged I2C master against i2c_slave_mem with an array/queue reference model.
module tb_i2c_slave_mem;
  localparam int Q = 8;
  logic clk = 1'b0, n_reset = 1'b0, m_scl = 1'b1, m_sda = 1'b1;
  logic sda_oe, busy, wr_valid;
  logic [7:0] wr_addr, wr_data;
  wire sda_bus = m_sda & ~sda_oe;
  int errors = 0, checks = 0, oe_viol = 0;
  logic oe_prev = 1'b0;
  logic [7:0] mem_m [256];
  logic [7:0] ptr_m = 8'h00;
  logic [15:0] wv_q[$], exp_q[$];
  logic [7:0] wbuf[$], rbuf[$], ebuf[$];

  always #5 clk = ~clk;

  i2c_slave_mem dut (
    .clk(clk), .n_reset(n_reset), .scl(m_scl), .sda_i(sda_bus), .sda_oe(sda_oe),
    .busy(busy), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always @(negedge clk) begin
    if (wr_valid) wv_q.push_back({wr_addr, wr_data});
    if (sda_oe && !oe_prev && m_scl) oe_viol++;
    oe_prev = sda_oe;
  end

  task automatic q_wait(); repeat (Q) @(posedge clk); #2; endtask
  task automatic i2c_start(); m_sda = 1; q_wait(); m_scl = 1; q_wait(); m_sda = 0; q_wait(); m_scl = 0; q_wait(); endtask
  task automatic i2c_stop(); m_sda = 0; q_wait(); m_scl = 1; q_wait(); m_sda = 1; q_wait(); endtask
  task automatic i2c_bit(input logic b, output logic r);
    m_sda = b; q_wait(); m_scl = 1; q_wait(); r = sda_bus; q_wait(); m_scl = 0; q_wait();
  endtask
  task automatic wr_byte(input logic [7:0] v, output logic nk);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(v[i], r);
    i2c_bit(1'b1, nk);
  endtask
  task automatic rd_byte(input logic nack, output logic [7:0] v);
    logic r;
    for (int i = 7; i >= 0; i--) begin i2c_bit(1'b1, r); v[i] = r; end
    i2c_bit(nack, r);
  endtask

  // Model: memory is 256 bytes, pointer wraps mod 256, upper address byte is ignored.
  task automatic do_write(input logic [15:0] a, input logic stop, output logic nk);
    logic k;
    i2c_start(); wr_byte(8'hA0, nk); wr_byte(a[15:8], k); nk |= k; wr_byte(a[7:0], k); nk |= k;
    ptr_m = a[7:0];
    foreach (wbuf[i]) begin
      wr_byte(wbuf[i], k); nk |= k;
      mem_m[ptr_m] = wbuf[i]; exp_q.push_back({ptr_m, wbuf[i]}); ptr_m++;
    end
    if (stop) i2c_stop();
  endtask
  task automatic do_read(input logic set_addr, input logic [15:0] a, input int n, input logic stop, output logic nk);
    logic k;
    logic [7:0] v;
    nk = 0; rbuf = {}; ebuf = {};
    if (set_addr) begin
      i2c_start(); wr_byte(8'hA0, k); nk |= k; wr_byte(a[15:8], k); nk |= k; wr_byte(a[7:0], k); nk |= k;
      ptr_m = a[7:0];
    end
    i2c_start(); wr_byte(8'hA1, k); nk |= k;
    for (int i = 0; i < n; i++) begin
      rd_byte(i == n - 1, v); rbuf.push_back(v); ebuf.push_back(mem_m[ptr_m]); ptr_m++;
    end
    if (stop) i2c_stop();
  endtask

  task automatic test_reset();
    n_reset = 0; repeat (3) @(posedge clk); #2;
    checks += 5;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
    if (wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr got=%h exp=00", wr_addr); end
    if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
    n_reset = 1; q_wait();
  endtask

  task automatic test_write();
    logic nk;
    wbuf = {8'h5A, 8'hC3}; exp_q = {}; wv_q = {};
    do_write(16'h0010, 1'b0, nk);
    checks += 3;
    if (nk !== 1'b0) begin errors++; $display("FAIL write_acks got=%b exp=0", nk); end
    if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got=%b exp=1", busy); end
    i2c_stop();
    if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop got=%b exp=0", busy); end
    checks++;
    if (wv_q.size() != 2) begin errors++; $display("FAIL write_pulses got=%0d exp=2", wv_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= wv_q.size() || wv_q[i] !== exp_q[i]) begin errors++; $display("FAIL write_strobe%0d got=%h exp=%h", i, i < wv_q.size() ? wv_q[i] : 16'hxxxx, exp_q[i]); end
    end
  endtask

  task automatic test_fill();
    logic nk;
    wbuf = {}; exp_q = {}; wv_q = {};
    for (int i = 0; i < 16; i++) wbuf.push_back(8'($urandom));
    do_write(16'h0012, 1'b1, nk);
    checks += 2;
    if (nk !== 1'b0) begin errors++; $display("FAIL fill_acks got=%b exp=0", nk); end
    if (wv_q != exp_q) begin errors++; $display("FAIL fill_strobes got=%0d exp=%0d entries", wv_q.size(), exp_q.size()); end
  endtask

  task automatic test_random_read();
    logic nk;
    do_read(1'b1, 16'h0010, 2, 1'b1, nk);
    checks++;
    if (nk !== 1'b0) begin errors++; $display("FAIL rread_acks got=%b exp=0", nk); end
    foreach (ebuf[i]) begin
      checks++;
      if (rbuf[i] !== ebuf[i]) begin errors++; $display("FAIL rread_byte%0d got=%h exp=%h", i, rbuf[i], ebuf[i]); end
    end
    do_read(1'b0, 16'h0, 1, 1'b1, nk);
    checks++;
    if (rbuf[0] !== ebuf[0]) begin errors++; $display("FAIL rread_ptr_0x12 got=%h exp=%h", rbuf[0], ebuf[0]); end
  endtask

  task automatic test_mismatch();
    logic k, nk;
    wv_q = {};
    i2c_start(); wr_byte(8'hA2, k);
    checks += 2;
    if (k !== 1'b1) begin errors++; $display("FAIL mismatch_ack got=%b exp=1", k); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy got=%b exp=0", busy); end
    wr_byte(8'($urandom), k);
    checks++;
    if (k !== 1'b1) begin errors++; $display("FAIL mismatch_ignored_ack got=%b exp=1", k); end
    do_read(1'b0, 16'h0, 1, 1'b1, nk);
    checks += 3;
    if (nk !== 1'b0) begin errors++; $display("FAIL mismatch_next_ack got=%b exp=0", nk); end
    if (rbuf[0] !== ebuf[0]) begin errors++; $display("FAIL mismatch_next_data got=%h exp=%h", rbuf[0], ebuf[0]); end
    if (wv_q.size() != 0) begin errors++; $display("FAIL mismatch_wr_valid got=%0d exp=0", wv_q.size()); end
  endtask

  task automatic test_wrap();
    logic nk;
    wbuf = {8'hAA, 8'hBB}; exp_q = {}; wv_q = {};
    do_write(16'h00FF, 1'b1, nk);
    wbuf = {8'($urandom)};
    do_write(16'h01FF, 1'b1, nk);
    checks += 2;
    if (wv_q != exp_q) begin errors++; $display("FAIL wrap_strobes got=%0d entries exp=%0d", wv_q.size(), exp_q.size()); end
    if (wv_q.size() < 2 || wv_q[1] !== 16'h00BB) begin errors++; $display("FAIL wrap_second got=%h exp=00bb", wv_q.size() < 2 ? 16'hxxxx : wv_q[1]); end
    do_read(1'b1, 16'h00FF, 2, 1'b1, nk);
    foreach (ebuf[i]) begin
      checks++;
      if (rbuf[i] !== ebuf[i]) begin errors++; $display("FAIL wrap_read%0d got=%h exp=%h", i, rbuf[i], ebuf[i]); end
    end
  endtask

  task automatic test_current_read();
    logic nk, k;
    wbuf = {};
    do_write(16'h0020, 1'b1, nk);
    do_read(1'b0, 16'h0, 1, 1'b0, nk);
    checks += 3;
    if (rbuf[0] !== ebuf[0]) begin errors++; $display("FAIL cur_read got=%h exp=%h", rbuf[0], ebuf[0]); end
    if (busy !== 1'b0) begin errors++; $display("FAIL cur_busy_nack got=%b exp=0", busy); end
    wr_byte(8'h00, k);
    if (k !== 1'b1) begin errors++; $display("FAIL cur_wait_stop_ack got=%b exp=1", k); end
    i2c_stop();
  endtask

  task automatic test_random();
    logic nk;
    logic [15:0] a;
    for (int t = 0; t < 5; t++) begin
      a = 16'($urandom); wbuf = {}; exp_q = {}; wv_q = {};
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) wbuf.push_back(8'($urandom));
      do_write(a, 1'b1, nk);
      checks += 2;
      if (nk !== 1'b0) begin errors++; $display("FAIL rand%0d_acks got=%b exp=0", t, nk); end
      if (wv_q != exp_q) begin errors++; $display("FAIL rand%0d_strobes got=%0d exp=%0d", t, wv_q.size(), exp_q.size()); end
      do_read(1'b1, a, wbuf.size(), 1'b1, nk);
      foreach (ebuf[i]) begin
        checks++;
        if (rbuf[i] !== ebuf[i]) begin errors++; $display("FAIL rand%0d_read%0d got=%h exp=%h", t, i, rbuf[i], ebuf[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic k, r, nk;
    logic [15:0] a;
    a = {8'h00, 8'($urandom_range(1, 255))};
    wbuf = {8'($urandom) & 8'hEF};
    do_write(a, 1'b1, nk);
    i2c_start(); wr_byte(8'hA0, k); wr_byte(a[15:8], k); wr_byte(a[7:0], k);
    i2c_start(); wr_byte(8'hA1, k);
    for (int i = 0; i < 3; i++) i2c_bit(1'b1, r);
    m_sda = 1; q_wait(); m_scl = 1; repeat (3) @(posedge clk); #1;
    checks += 4;
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL rstmid_driving got=%b exp=1", sda_oe); end
    if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    n_reset = 0; #1;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL rstmid_sda_oe got=%b exp=0", sda_oe); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    m_sda = 1; repeat (4) @(posedge clk); #2; n_reset = 1; q_wait();
    ptr_m = 8'h00;
    do_read(1'b0, 16'h0, 1, 1'b1, nk);
    checks += 2;
    if (nk !== 1'b0) begin errors++; $display("FAIL rstmid_after_ack got=%b exp=0", nk); end
    if (rbuf[0] !== ebuf[0]) begin errors++; $display("FAIL rstmid_after_data got=%h exp=%h", rbuf[0], ebuf[0]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_fill();
    test_random_read();
    test_mismatch();
    test_wrap();
    test_current_read();
    test_random();
    test_reset_mid();
    checks++;
    if (oe_viol != 0) begin errors++; $display("FAIL sda_oe_rise_while_scl_high got=%0d exp=0", oe_viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_slave_mem.md
Name: i2c_slave_mem

Overview:
I2C target (responder) that answers the team's i2c_ctrl master. It presents a small byte-addressable memory that behaves like a 24-series EEPROM with 16-bit byte addressing. The block oversamples SCL/SDA on clk and drives SDA open-drain through an output-enable. It is used as the on-board loopback target and as the bench model for the master.

Parameters:
DEVICE_ADDR, 7'b1010_000, 7-bit target address matched after START
ADDR_BITS, 8, memory index width; DEPTH = 2**ADDR_BITS bytes
SYNC_STAGES, 2, synchronizer flops on scl and sda_i (minimum 2)

Ports:
clk  input  1  system clock; must be at least 16x SCL (50 MHz vs 250 kHz nominal)
n_reset  input  1  asynchronous, active-low reset
scl  input  1  I2C clock from the master (input only, no clock stretching)
sda_i  input  1  resolved SDA bus level
sda_oe  output  1  1 = pull SDA low; 0 = release (top level ties sda = sda_oe ? 1'b0 : 1'bz)
busy  output  1  high from START with an address match until STOP or NACK end
wr_valid  output  1  one-clk pulse per committed write byte
wr_addr  output  ADDR_BITS  memory index of the committed byte
wr_data  output  8  committed byte

Behaviour:
- Reset: sda_oe=0, busy=0, wr_valid=0, wr_addr=0, wr_data=0. Pointer=0, state=IDLE, shift register=0. Memory contents are not cleared.
- Synchronize scl and sda_i through SYNC_STAGES flops; keep a one-cycle-delayed copy for edge detection.
- scl_rise and scl_fall are single-cycle strobes.
- START: synced SDA falls while synced SCL is high. Legal from any state (repeated start included): goto DEV_ADDR, bit count=0, sda_oe=0.
- STOP: synced SDA rises while SCL is high. From any state: goto IDLE, sda_oe=0, busy=0.
- If START/STOP coincides with an scl edge in the same cycle, START/STOP wins.
- Data is sampled on scl_rise, MSB first. sda_oe changes only on scl_fall.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits. On the 8th scl_fall:
    - address match: sda_oe=1 (ACK), busy=1, goto ACK_DEV.
    - mismatch: goto WAIT_STOP, no ACK.
  - ACK_DEV: on the next scl_fall, sda_oe=0.
    - R/W=0: goto ADDR_HI.
    - R/W=1: load mem[pointer], drive its MSB (sda_oe=~bit), goto RD_DATA. This is a current-address read.
  - ADDR_HI / ADDR_LO: receive 8 bits each, ACK each through ACK_HI / ACK_LO, same timing as ACK_DEV.
    - Pointer = {hi,lo} truncated to ADDR_BITS; the upper bits are ignored.
    - After ACK_LO goto WR_DATA.
  - WR_DATA: on the 8th scl_rise, write mem[pointer]=byte and pulse wr_valid with wr_addr=pointer, wr_data=byte. On the 8th scl_fall, ACK; goto ACK_WR.
  - ACK_WR: release on scl_fall, pointer+1 (wraps DEPTH-1 -> 0), goto WR_DATA.
  - A repeated START after ACK_LO (random read) keeps the pointer.
  - RD_DATA: drive bits 6..0 on successive scl_fall. On the 8th scl_fall, sda_oe=0; goto RD_ACK.
  - RD_ACK: sample master ACK on scl_rise.
    - 0: pointer+1 (wrap); on scl_fall load the next byte and drive its MSB; goto RD_DATA.
    - 1 (NACK): pointer+1, busy=0, goto WAIT_STOP.
  - WAIT_STOP: sda_oe=0; ignore bits until START or STOP.
- The target never pulls SDA low while SCL is high, except to hold an ACK/data bit already driven.
- Reset asserted mid-transfer: immediate sda_oe=0, busy=0, state IDLE. The pointer resets to 0.

Test Plan:
- Write 0xA0,0x00,0x10,0x5A,0xC3,STOP -> three ACKs plus two data ACKs; wr_valid pulses (addr 0x10, 0x5A) then (0x11, 0xC3); busy falls at STOP.
- Random read: 0xA0,0x00,0x10, Sr, 0xA1, read 2 bytes with ACK then NACK, STOP -> SDA returns 0x5A then 0xC3; the pointer ends at 0x12.
- Address mismatch 0xA2 -> SDA high at the 9th clock, busy stays 0, no wr_valid; the next valid START is accepted.
- Wrap-around: write 0xAA at 0x00FF and 0xBB next -> the second byte lands at 0x00; address 0x01FF aliases to 0xFF.
- Current-address read after STOP with pointer 0x20 (0xA1, NACK) -> returns mem[0x20]; state goes to WAIT_STOP.
- Assert n_reset during the 4th bit of a read byte -> sda_oe=0 on the same cycle, busy=0; the next transaction starts cleanly from START.
